nios2_system_nios2_system_oci_dct_packer: RTL and testbench
===========================================================

# nios2_system_nios2_system_oci_dct_packer

Packs the Nios II OCI direct/conditional branch-trace codes (2 bits per branch) into the 30-bit `dct_buffer` / 4-bit `dct_count` pair and emits complete trace frames to the trace-memory writer. It is the producing end of the dct interface, sitting between the CPU branch-resolve stage and the OCI trace FIFO. It runs on the CPU clock and never stalls the CPU: entries that cannot be stored are dropped and flagged.

## Interface
- Parameters: none. Widths are fixed at 15 entries × 2 bits.
- `clk` input 1 — CPU clock.
- `reset_n` input 1 — asynchronous, active-low reset.
- `trc_on` input 1 — trace enable.
- `br_valid` input 1 — a branch resolved this cycle.
- `br_code` input 2 — 01 taken, 10 not-taken, 11 indirect marker, 00 reserved.
- `flush_req` input 1 — single-cycle request to emit a partial frame.
- `frame_ready` input 1 — downstream accepts the frame.
- `dct_buffer` output 30 — packed entries; newest entry in [1:0].
- `dct_count` output 4 — number of valid entries, 0..15.
- `frame_valid` output 1 — frame output register occupied.
- `frame_data` output 35 — {lost[34], count[33:30], buffer[29:0]}.
- `lost_any` output 1 — sticky: at least one entry dropped since reset.

## Operation
- Accept condition: `trc_on & br_valid & (br_code != 00)`. Code 00 is ignored.
- Append on accept: `dct_buffer <= {dct_buffer[27:0], br_code}`, `dct_count <= dct_count + 1`.
- Emit condition (any one of):
  - count == 15;
  - `flush_req` with count != 0;
  - `trc_on` falling (registered previous value) with count != 0.
- The output slot is free when `!frame_valid | frame_ready`.
- Emit when the emit condition holds and the slot is free:
  - load `frame_data` with {lost_pend, count, buffer};
  - set `frame_valid`;
  - clear the buffer to 0 and the count to 0;
  - clear `lost_pend`.
- Accept on the same cycle as an emit: the new entry starts the fresh buffer (count = 1, buffer = {28'b0, code}). It is not included in the emitted frame.
- Full (count == 15) and slot busy: the accepted entry is dropped, buffer and count hold, and `lost_pend` and `lost_any` are set. The frame emits once the slot frees.
- Pending flush or trc_on-fall with the slot busy: the request is latched (`flush_pend`) and served when the slot frees. It is cleared if count reaches 0 by an emit.
- `frame_valid` clears on `frame_ready` unless a new frame loads in the same cycle.
- `trc_on` low: no appends. Existing contents are still flushable.
- State machine `st`:
  - PACK — count < 15, no pending flush.
  - FULL — count == 15, slot busy.
  - DRAIN — flush pending, slot busy.
  - PACK→FULL on append reaching 15 with the slot busy.
  - FULL/DRAIN→PACK on emit.
  - PACK→DRAIN on a flush request with count != 0 and the slot busy.

## Timing
- Reset values: `dct_buffer` 0, `dct_count` 0, `frame_valid` 0, `frame_data` 0, `lost_any` 0. Internal state is PACK, and `lost_pend`, `flush_pend` and previous-`trc_on` are all 0.
- All outputs are registered.
- Append latency: 1 cycle (visible on `dct_buffer`/`dct_count` the cycle after `br_valid`).
- Emit latency: `frame_valid` rises the cycle after the emit condition with a free slot. A 15th append and its emit therefore complete in 2 cycles.
- Handshake: a transfer occurs on `frame_valid & frame_ready` at a rising edge. `frame_data` is stable while `frame_valid & !frame_ready`.
- Back-to-back frames: sustained at 1 frame per 15 accepts with `frame_ready` held high, with no drops.
- Reset mid-frame: all contents are discarded and no partial frame is emitted.

## Structure
- Shared package `nios2_oci_dct_pkg` holds:
  - localparams `DCT_ENTRIES=15`, `DCT_W=30`, `DCT_CNT_W=4`, `FRAME_W=35`;
  - the `br_code` encodings;
  - the state enum.
- One sub-module is natural: `nios2_oci_dct_frame_reg`, the single-entry valid/ready output register with load/hold/clear.

## Test plan
- Reset, then 15 accepts of 01 with `frame_ready`=1 → frame_data = {0, 4'hF, 30'h15555555}, frame_valid 1 cycle; count returns to 0.
- 3 accepts (01, 10, 11) then `flush_req` → frame_data = {0, 4'h3, 30'h0000001B}.
- `frame_ready`=0, 15 accepts (frame 1 held), 15 more accepts, then 1 extra accept → extra entry dropped, `lost_any`=1. Raise `frame_ready` → frame 2 carries lost=1, count 15.
- Accept on the same cycle as the 15th-entry emit → emitted frame has count 15, and `dct_count`=1 with the new code in [1:0].
- Drop `trc_on` with count 5 and slot busy → DRAIN. Raise `frame_ready` → partial frame with count 5 follows. `br_valid` during `trc_on`=0 is ignored.
- Assert `reset_n`=0 with count 9 and frame_valid=1 → all outputs 0 asynchronously, and no frame after release.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared definitions for the OCI direct/conditional branch-trace packer.
package nios2_oci_dct_pkg;

  localparam int DCT_ENTRIES = 15;
  localparam int DCT_W       = 30;
  localparam int DCT_CNT_W   = 4;
  localparam int FRAME_W     = 35;

  // Branch-trace codes; 00 carries no information and is never stored.
  localparam logic [1:0] BR_RSVD      = 2'b00;
  localparam logic [1:0] BR_TAKEN     = 2'b01;
  localparam logic [1:0] BR_NOT_TAKEN = 2'b10;
  localparam logic [1:0] BR_INDIRECT  = 2'b11;

  // PACK: collecting. FULL: 15 entries waiting on the slot. DRAIN: partial
  // frame requested, waiting on the slot.
  typedef enum logic [1:0] {
    ST_PACK  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } dct_st_e;

  typedef struct packed {
    logic                 lost;
    logic [DCT_CNT_W-1:0] cnt;
    logic [DCT_W-1:0]     entries;
  } dct_frame_t;

endpackage

// File: rtl/nios2_oci_dct_frame_reg.sv
// Single-entry valid/ready output register: load, hold while stalled, clear on take.
module nios2_oci_dct_frame_reg
  import nios2_oci_dct_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  assign free = !valid | ready;

  // Load wins over the clear so back-to-back frames keep valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_system_nios2_system_oci_dct_packer.sv
// Packs 2-bit branch-trace codes into 15-entry frames; never stalls the CPU.
module nios2_system_nios2_system_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 trc_on,
  input  logic                 br_valid,
  input  logic [1:0]           br_code,
  input  logic                 flush_req,
  input  logic                 frame_ready,
  output logic [DCT_W-1:0]     dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 frame_valid,
  output logic [FRAME_W-1:0]   frame_data,
  output logic                 lost_any
);

  dct_st_e              st;
  logic                 lost_pend;
  logic                 trc_prev;
  logic                 slot_free;
  logic                 accept, cnt_full, cnt_nz, trc_fall, flush_hit;
  logic                 emit, drop;
  logic [DCT_W-1:0]     buf_nxt;
  logic [DCT_CNT_W-1:0] cnt_nxt;
  logic                 lost_nxt;
  dct_frame_t           frame_in;

  assign accept    = trc_on & br_valid & (br_code != BR_RSVD);
  assign cnt_full  = dct_count == DCT_CNT_W'(DCT_ENTRIES);
  assign cnt_nz    = dct_count != '0;
  assign trc_fall  = trc_prev & !trc_on;
  // A latched flush is represented by the DRAIN state itself.
  assign flush_hit = flush_req | trc_fall | (st == ST_DRAIN);
  assign emit      = (cnt_full | (cnt_nz & flush_hit)) & slot_free;
  assign drop      = accept & cnt_full & !slot_free;
  assign frame_in  = {lost_pend, dct_count, dct_buffer};

  // Next buffer/count: emit empties first, so a same-cycle accept opens the fresh frame.
  always_comb begin
    buf_nxt  = dct_buffer;
    cnt_nxt  = dct_count;
    lost_nxt = lost_pend;
    if (emit) begin
      buf_nxt  = '0;
      cnt_nxt  = '0;
      lost_nxt = 1'b0;
    end
    if (accept && (emit || !cnt_full)) begin
      buf_nxt = {buf_nxt[DCT_W-3:0], br_code};
      cnt_nxt = cnt_nxt + DCT_CNT_W'(1);
    end
    if (drop) lost_nxt = 1'b1;
  end

  // Packing datapath and loss flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      lost_pend  <= 1'b0;
      lost_any   <= 1'b0;
      trc_prev   <= 1'b0;
    end else begin
      dct_buffer <= buf_nxt;
      dct_count  <= cnt_nxt;
      lost_pend  <= lost_nxt;
      lost_any   <= lost_any | drop;
      trc_prev   <= trc_on;
    end
  end

  // Slot-wait state: FULL outranks DRAIN since a full buffer emits regardless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= ST_PACK;
    end else if (emit) begin
      st <= ST_PACK;
    end else if (cnt_nxt == DCT_CNT_W'(DCT_ENTRIES) && !slot_free) begin
      st <= ST_FULL;
    end else if (st == ST_DRAIN || ((flush_req || trc_fall) && cnt_nz)) begin
      st <= ST_DRAIN;
    end else begin
      st <= ST_PACK;
    end
  end

  nios2_oci_dct_frame_reg #(.W(FRAME_W)) u_frame (
    .clk   (clk),
    .rst_n (reset_n),
    .load  (emit),
    .din   (frame_in),
    .ready (frame_ready),
    .valid (frame_valid),
    .data  (frame_data),
    .free  (slot_free)
  );

endmodule

// File: tb/tb_nios2_system_nios2_system_oci_dct_packer.sv
// Scoreboard bench: stimulus pushes expected frames, a monitor pops on each transfer.
module tb_nios2_system_nios2_system_oci_dct_packer;
  import nios2_oci_dct_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              trc_on = 1'b0;
  logic              br_valid = 1'b0;
  logic [1:0]        br_code = 2'b00;
  logic              flush_req = 1'b0;
  logic              frame_ready = 1'b0;
  logic [29:0]       dct_buffer;
  logic [3:0]        dct_count;
  logic              frame_valid;
  logic [34:0]       frame_data;
  logic              lost_any;

  int n_cmp = 0;
  int n_bad = 0;
  logic [34:0] exp_q[$];

  nios2_system_nios2_system_oci_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trc_on      (trc_on),
    .br_valid    (br_valid),
    .br_code     (br_code),
    .flush_req   (flush_req),
    .frame_ready (frame_ready),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .lost_any    (lost_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [1:0] c);
    br_valid = 1'b1;
    br_code  = c;
    tick();
    br_valid = 1'b0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid & ready.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got %h expected none", frame_data);
        end else begin
          e = exp_q.pop_front();
          chk("frame_data", {29'd0, frame_data}, {29'd0, e});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_count", {60'd0, dct_count}, 64'd0);
    chk("rst_valid", {63'd0, frame_valid}, 64'd0);
    chk("rst_data", {29'd0, frame_data}, 64'd0);
    chk("rst_lost", {63'd0, lost_any}, 64'd0);
    trc_on = 1'b1;
    frame_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    // 15 taken entries emit a full frame
    exp_q.push_back({1'b0, 4'hF, 30'h15555555});
    for (int i = 0; i < 15; i++) acc(BR_TAKEN);
    chk("t1_count15", {60'd0, dct_count}, 64'd15);
    tick();
    chk("t1_count0", {60'd0, dct_count}, 64'd0);
    chk("t1_lost", {63'd0, lost_any}, 64'd0);
    tick();

    // Partial frame via flush
    acc(BR_TAKEN); acc(BR_NOT_TAKEN); acc(BR_INDIRECT);
    chk("t2_buffer", {34'd0, dct_buffer}, 64'h1B);
    exp_q.push_back({1'b0, 4'h3, 30'h0000001B});
    flush();
    chk("t2_count0", {60'd0, dct_count}, 64'd0);
    tick(); tick();

    // Stalled slot: second full frame overflows and carries the lost flag
    frame_ready = 1'b0;
    exp_q.push_back({1'b0, 4'hF, 30'h15555555});
    exp_q.push_back({1'b1, 4'hF, 30'h2AAAAAAA});
    for (int i = 0; i < 15; i++) acc(BR_TAKEN);
    for (int i = 0; i < 15; i++) acc(BR_NOT_TAKEN);
    acc(BR_INDIRECT);
    chk("t3_count", {60'd0, dct_count}, 64'd15);
    chk("t3_buffer", {34'd0, dct_buffer}, 64'h2AAAAAAA);
    chk("t3_lost_any", {63'd0, lost_any}, 64'd1);
    chk("t3_held_valid", {63'd0, frame_valid}, 64'd1);
    chk("t3_held_data", {29'd0, frame_data}, {29'd0, 1'b0, 4'hF, 30'h15555555});
    frame_ready = 1'b1;
    tick();
    chk("t3_count0", {60'd0, dct_count}, 64'd0);
    tick(); tick();

    // Accept on the same cycle as the full-frame emit
    exp_q.push_back({1'b0, 4'hF, 30'h3FFFFFFF});
    for (int i = 0; i < 15; i++) acc(BR_INDIRECT);
    acc(BR_TAKEN);
    chk("t4_count1", {60'd0, dct_count}, 64'd1);
    chk("t4_buffer", {34'd0, dct_buffer}, 64'h1);
    exp_q.push_back({1'b0, 4'h1, 30'h00000001});
    flush();
    tick(); tick();

    // trc_on fall with slot busy, then drain once the slot frees
    frame_ready = 1'b0;
    acc(BR_TAKEN); acc(BR_TAKEN);
    exp_q.push_back({1'b0, 4'h2, 30'h00000005});
    flush();
    for (int i = 0; i < 5; i++) acc(BR_NOT_TAKEN);
    chk("t5_count5", {60'd0, dct_count}, 64'd5);
    trc_on = 1'b0;
    br_valid = 1'b1;
    br_code = BR_TAKEN;
    tick(); tick(); tick();
    chk("t5_ign_count", {60'd0, dct_count}, 64'd5);
    chk("t5_ign_buffer", {34'd0, dct_buffer}, 64'h2AA);
    br_valid = 1'b0;
    exp_q.push_back({1'b0, 4'h5, 30'h000002AA});
    frame_ready = 1'b1;
    tick();
    chk("t5_count0", {60'd0, dct_count}, 64'd0);
    tick(); tick();

    // Reset mid-frame discards everything
    trc_on = 1'b1;
    frame_ready = 1'b0;
    acc(BR_TAKEN);
    flush();
    for (int i = 0; i < 9; i++) acc(BR_TAKEN);
    chk("t6_pre_count", {60'd0, dct_count}, 64'd9);
    chk("t6_pre_valid", {63'd0, frame_valid}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_count", {60'd0, dct_count}, 64'd0);
    chk("t6_buffer", {34'd0, dct_buffer}, 64'd0);
    chk("t6_valid", {63'd0, frame_valid}, 64'd0);
    chk("t6_data", {29'd0, frame_data}, 64'd0);
    chk("t6_lost", {63'd0, lost_any}, 64'd0);
    tick();
    reset_n = 1'b1;
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_post_valid", {63'd0, frame_valid}, 64'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
